// File: rtl/lcd_display_timed_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_display_timed_ctrl
//
// Avalon-MM slave that drives an HD44780-style character LCD. Each bus access
// is stretched by a hardware timing FSM into setup, enable-pulse and hold
// phases. The master is stalled with waitrequest for the whole access.
// Register map: address[1] -> LCD_RS, address[0] -> LCD_RW (1 = read).
//
// Parameters
//   SETUP_CYC   clk cycles RS/RW/data are stable before LCD_E rises (>=1)
//   E_HIGH_CYC  clk cycles LCD_E stays high (>=1)
//   HOLD_CYC    clk cycles RS/RW/data are held after LCD_E falls (>=1)
//   CNT_W       phase counter width; every *_CYC must be < 2**CNT_W
//
// Ports
//   clk          in    system clock
//   reset        in    asynchronous reset, active-high
//   address[1:0] in    [1]=RS, [0]=RW
//   read, write  in    Avalon requests (read & write together = write)
//   writedata    in    byte sent to the LCD
//   readdata     out   byte read from the LCD, held until the next read
//   waitrequest  out   Avalon stall
//   LCD_E        out   enable strobe (registered)
//   LCD_RS       out   register select (registered)
//   LCD_RW       out   1 = LCD drives the bus (registered)
//   LCD_data     inout LCD data bus, 8 bits (4 bits in nibble mode)
//
// Configuration macro
//   LCD_NIBBLE_MODE_EN : when defined, the bus is 4 bits wide and every access
//   runs two SETUP/PULSE/HOLD passes, upper nibble first.
// -----------------------------------------------------------------------------
module lcd_display_timed_ctrl #(
    parameter int SETUP_CYC  = 4,
    parameter int E_HIGH_CYC = 12,
    parameter int HOLD_CYC   = 4,
    parameter int CNT_W      = 8,
`ifdef LCD_NIBBLE_MODE_EN
    localparam int  DW     = 4,
    localparam bit  NIBBLE = 1'b1
`else
    localparam int  DW     = 8,
    localparam bit  NIBBLE = 1'b0
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    address,
    input  logic          read,
    input  logic          write,
    input  logic [7:0]    writedata,
    output logic [7:0]    readdata,
    output logic          waitrequest,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW,
    inout  wire  [DW-1:0] LCD_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic             e_q, e_d;
    logic             oe_q, oe_d;
    logic             rd_q, rd_d;
    logic             pass_q, pass_d;
    // Outgoing byte; in nibble mode the low nibble is shifted up for pass two.
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       readdata_q, readdata_d;
`ifdef LCD_NIBBLE_MODE_EN
    // Upper nibble of a read, committed to readdata only after pass two.
    logic [3:0]       rd_hi_q, rd_hi_d;
`endif

    assign readdata    = readdata_q;
    assign LCD_E       = e_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = rw_q;
    assign LCD_data    = oe_q ? dout_q[7 -: DW] : {DW{1'bz}};
    assign waitrequest = (read | write) & (state_q != S_DONE);

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rs_d       = rs_q;
        rw_d       = rw_q;
        e_d        = e_q;
        oe_d       = oe_q;
        rd_d       = rd_q;
        pass_d     = pass_q;
        dout_d     = dout_q;
        readdata_d = readdata_q;
`ifdef LCD_NIBBLE_MODE_EN
        rd_hi_d    = rd_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                e_d    = 1'b0;
                oe_d   = 1'b0;
                rw_d   = 1'b1;
                pass_d = 1'b0;
                cnt_d  = CNT_ZERO;
                if (read | write) begin
                    // Bus direction is only ever changed here, with E low.
                    rs_d    = address[1];
                    rw_d    = address[0];
                    oe_d    = ~address[0];
                    rd_d    = read & ~write;
                    dout_d  = writedata;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = CNT_ZERO;
                    e_d     = 1'b1;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == E_LAST) begin
                    cnt_d   = CNT_ZERO;
                    e_d     = 1'b0;
                    state_d = S_HOLD;
                    // Sample the LCD on the last cycle E is high.
                    if (rd_q) begin
`ifdef LCD_NIBBLE_MODE_EN
                        if (pass_q) begin
                            readdata_d = {rd_hi_q, LCD_data};
                        end else begin
                            rd_hi_d = LCD_data;
                        end
`else
                        readdata_d = LCD_data;
`endif
                    end else begin
                        readdata_d = readdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (NIBBLE && !pass_q) begin
                        // Second pass: RS/RW and drive enable stay as they are.
                        pass_d  = 1'b1;
                        dout_d  = {dout_q[3:0], 4'h0};
                        state_d = S_SETUP;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                rw_d    = 1'b1;
                oe_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                e_d     = 1'b0;
                oe_d    = 1'b0;
                rw_d    = 1'b1;
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces E low and the bus to Z at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            rs_q       <= 1'b0;
            rw_q       <= 1'b1;
            e_q        <= 1'b0;
            oe_q       <= 1'b0;
            rd_q       <= 1'b0;
            pass_q     <= 1'b0;
            dout_q     <= 8'h00;
            readdata_q <= 8'h00;
`ifdef LCD_NIBBLE_MODE_EN
            rd_hi_q    <= 4'h0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            e_q        <= e_d;
            oe_q       <= oe_d;
            rd_q       <= rd_d;
            pass_q     <= pass_d;
            dout_q     <= dout_d;
            readdata_q <= readdata_d;
`ifdef LCD_NIBBLE_MODE_EN
            rd_hi_q    <= rd_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_display_timed_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lcd_display_timed_ctrl: a table of directed accesses
// followed by hand-written sequences for dropped requests and mid-pulse reset.
// A small LCD model drives the bus while RW=1 and E=1; a probe driver is used
// to show the DUT has released the bus.
// -----------------------------------------------------------------------------
module tb_lcd_display_timed_ctrl;

    localparam int SETUP_CYC  = 4;
    localparam int E_HIGH_CYC = 12;
    localparam int HOLD_CYC   = 4;
`ifdef LCD_NIBBLE_MODE_EN
    localparam int DW = 4;
    localparam int NP = 2;
`else
    localparam int DW = 8;
    localparam int NP = 1;
`endif
    localparam int EXP_LAT  = NP * (SETUP_CYC + E_HIGH_CYC + HOLD_CYC) + 2;
    localparam int EXP_GAP  = (NP == 2) ? (HOLD_CYC + SETUP_CYC) : (HOLD_CYC + 2 + SETUP_CYC);
    localparam int EXP_RISE = SETUP_CYC + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          read;
    logic          write;
    logic [7:0]    writedata;
    logic [7:0]    readdata;
    logic          waitrequest;
    logic          LCD_E;
    logic          LCD_RS;
    logic          LCD_RW;
    wire  [DW-1:0] lcd_bus;

    int n_chk  = 0;
    int n_fail = 0;

    // LCD model / probe drivers
    logic          probe_en = 1'b0;
    logic [DW-1:0] probe_val = '0;
    logic [7:0]    lcd_val = 8'h00;
    logic [DW-1:0] model_val;
    int            e_falls = 0;
    int            start_falls = 0;
    int            low_run = 0;
    int            last_gap = 0;
    logic          mon_prev_e = 1'b0;

    // Per-access results, written only by xfer
    int         r_lat, r_elen0, r_elen1, r_np, r_rise;
    logic [7:0] r_bus0, r_bus1, r_bus_setup, r_rdata;
    logic       r_rs, r_rw, r_rw_after, r_wait0;

    always #5 clk = ~clk;

    lcd_display_timed_ctrl #(
        .SETUP_CYC  (SETUP_CYC),
        .E_HIGH_CYC (E_HIGH_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_data    (lcd_bus)
    );

    // Portion of a byte carried by pulse p (whole byte on an 8-bit bus).
    function automatic logic [7:0] part(input logic [7:0] v, input int p);
        if (DW == 8) return v;
        else if (p == 0) return {4'h0, v[7:4]};
        else return {4'h0, v[3:0]};
    endfunction

    always_comb model_val = DW'(part(lcd_val, e_falls - start_falls));

    assign lcd_bus = probe_en ? probe_val :
                     (LCD_RW && LCD_E) ? model_val : {DW{1'bz}};

    // E-low gap and falling-edge tracker
    always @(negedge clk) begin
        if (LCD_E) begin
            if (!mon_prev_e) last_gap <= low_run;
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        if (mon_prev_e && !LCD_E) e_falls <= e_falls + 1;
        mon_prev_e <= LCD_E;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One access, called at a negedge. drop_after>0 releases the request after
    // that many edges and simply runs 30 edges instead of waiting for completion.
    task automatic xfer(input logic [1:0] a, input logic rd, input logic wr,
                        input logic [7:0] wd, input logic [7:0] lv, input int drop_after);
        logic prev;
        logic fin;
        logic done;
        lcd_val     = lv;
        start_falls = e_falls;
        address     = a;
        read        = rd;
        write       = wr;
        writedata   = wd;
        #1;
        r_wait0 = waitrequest;
        r_lat = 0; r_elen0 = 0; r_elen1 = 0; r_np = 0; r_rise = -1;
        r_bus0 = 8'h00; r_bus1 = 8'h00; r_bus_setup = 8'h00; r_rdata = 8'h00;
        r_rs = 1'b0; r_rw = 1'b0;
        prev = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (LCD_E) begin
                if (r_rise < 0) r_rise = r_lat;
                if (r_np == 0) begin
                    r_elen0++;
                    r_bus0 = 8'(lcd_bus);
                end else begin
                    r_elen1++;
                    r_bus1 = 8'(lcd_bus);
                end
                r_rs = LCD_RS;
                r_rw = LCD_RW;
            end else if (prev) begin
                r_np++;
            end
            prev = LCD_E;
            if (r_lat == 1) r_bus_setup = 8'(lcd_bus);
            fin = (drop_after > 0) ? (r_lat >= 29) : !waitrequest;
            if (fin && drop_after == 0) r_rdata = readdata;
            @(posedge clk);
            r_lat++;
            if (drop_after > 0 && r_lat == drop_after) begin
                read  = 1'b0;
                write = 1'b0;
            end
            if (fin) done = 1'b1;
            @(negedge clk);
        end
        read  = 1'b0;
        write = 1'b0;
        r_rw_after = LCD_RW;
        if (!done) chk("access_timeout", 32'(r_lat), 32'(0));
    endtask

    typedef struct {
        logic [1:0] addr;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] lcd_val;
        logic       exp_rs;
        logic       exp_rw;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       is_rd;
        logic [7:0] exp_val;

        vecs[0] = '{2'b10, 1'b0, 1'b1, 8'h41, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{2'b01, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 8'h80};
        vecs[2] = '{2'b00, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h80};
        vecs[3] = '{2'b00, 1'b0, 1'b1, 8'h38, 8'h00, 1'b0, 1'b0, 8'h80};
        vecs[4] = '{2'b11, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 8'hA5, 8'hFF, 1'b1, 1'b0, 8'h5A};

        reset = 1'b1; address = 2'b00; read = 1'b0; write = 1'b0; writedata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_E", 32'(LCD_E), 32'(0));
        chk("reset_RS", 32'(LCD_RS), 32'(0));
        chk("reset_RW", 32'(LCD_RW), 32'(1));
        chk("reset_readdata", 32'(readdata), 32'(0));
        probe_val = DW'(8'hC3);
        probe_en  = 1'b1;
        #1 chk("reset_bus_z", 32'(lcd_bus), 32'(DW'(8'hC3)));
        probe_en  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_waitrequest", 32'(waitrequest), 32'(0));

        // Table: back-to-back accesses, each issued in the IDLE cycle after DONE.
        for (int i = 0; i < 6; i++) begin
            is_rd   = vecs[i].rd & ~vecs[i].wr;
            exp_val = is_rd ? vecs[i].lcd_val : vecs[i].wdata;
            xfer(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].lcd_val, 0);
            chk($sformatf("v%0d_wait_comb", i), 32'(r_wait0), 32'(1));
            chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(EXP_LAT));
            chk($sformatf("v%0d_pulses", i), 32'(r_np), 32'(NP));
            chk($sformatf("v%0d_e_rise", i), 32'(r_rise), 32'(EXP_RISE));
            chk($sformatf("v%0d_e_len0", i), 32'(r_elen0), 32'(E_HIGH_CYC));
            chk($sformatf("v%0d_rs", i), 32'(r_rs), 32'(vecs[i].exp_rs));
            chk($sformatf("v%0d_rw", i), 32'(r_rw), 32'(vecs[i].exp_rw));
            chk($sformatf("v%0d_bus0", i), 32'(r_bus0), 32'(part(exp_val, 0)));
            if (NP == 2) begin
                chk($sformatf("v%0d_e_len1", i), 32'(r_elen1), 32'(E_HIGH_CYC));
                chk($sformatf("v%0d_bus1", i), 32'(r_bus1), 32'(part(exp_val, 1)));
            end
            if (!is_rd)
                chk($sformatf("v%0d_bus_setup", i), 32'(r_bus_setup), 32'(part(exp_val, 0)));
            chk($sformatf("v%0d_readdata", i), 32'(r_rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_rw_idle", i), 32'(r_rw_after), 32'(1));
            if (i > 0 || NP == 2)
                chk($sformatf("v%0d_e_low_gap", i), 32'(last_gap), 32'(EXP_GAP));
        end

        // Request dropped after 3 edges: full pulse(s) still produced.
        repeat (2) @(negedge clk);
        xfer(2'b00, 1'b0, 1'b1, 8'h0C, 8'h00, 3);
        chk("drop_pulses", 32'(r_np), 32'(NP));
        chk("drop_e_len0", 32'(r_elen0), 32'(E_HIGH_CYC));
        chk("drop_bus0", 32'(r_bus0), 32'(part(8'h0C, 0)));
        chk("drop_E_low_after", 32'(LCD_E), 32'(0));
        xfer(2'b00, 1'b0, 1'b1, 8'h06, 8'h00, 0);
        chk("after_drop_latency", 32'(r_lat), 32'(EXP_LAT));
        chk("after_drop_bus0", 32'(r_bus0), 32'(part(8'h06, 0)));

        // Reset asserted in the middle of the enable pulse.
        repeat (2) @(negedge clk);
        address = 2'b10; writedata = 8'h41; write = 1'b1;
        repeat (8) @(negedge clk);
        chk("pre_reset_E_high", 32'(LCD_E), 32'(1));
        reset = 1'b1;
        #1 chk("midreset_E", 32'(LCD_E), 32'(0));
        probe_val = DW'(8'h96);
        probe_en  = 1'b1;
        #1 chk("midreset_bus_z", 32'(lcd_bus), 32'(DW'(8'h96)));
        probe_en = 1'b0;
        write    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        xfer(2'b10, 1'b0, 1'b1, 8'h4D, 8'h00, 0);
        chk("post_reset_latency", 32'(r_lat), 32'(EXP_LAT));
        chk("post_reset_e_len0", 32'(r_elen0), 32'(E_HIGH_CYC));
        chk("post_reset_bus0", 32'(r_bus0), 32'(part(8'h4D, 0)));
        chk("post_reset_rs", 32'(r_rs), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
